// File: rtl/line_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// line_arbiter_pkg : shared types and default widths for the line arbiter
// Revision 1.0
// ============================================================================
package line_arbiter_pkg;

    localparam int DEF_NUM_REQ = 3;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_LINE_W  = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage : line_arbiter_pkg
`default_nettype wire

// File: rtl/line_arbiter_picker.sv
`default_nettype none
// ============================================================================
// rr_picker : picks the first active request at or after a start pointer
// Revision 1.0
// ============================================================================
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               valid_o
);

    always_comb begin
        int idx;
        idx     = 0;
        grant_o = '0;
        valid_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Wrap the search index so the scan starts at the pointer.
            idx = int'(ptr_i) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!valid_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule : rr_picker
`default_nettype wire

// File: rtl/line_arbiter.sv
`default_nettype none
// ============================================================================
// line_arbiter : N-way cacheline arbiter in front of a single memory port.
// Define LINE_ARBITER_RR_EN for round-robin selection (fixed priority else).
// Revision 1.0
// ============================================================================
module line_arbiter
    import line_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LINE_W  = DEF_LINE_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_read,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_address,
    input  logic [NUM_REQ-1:0][LINE_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]               req_resp,
    output logic [NUM_REQ-1:0][LINE_W-1:0]   req_rdata,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [ADDR_W-1:0]                mem_address,
    output logic [LINE_W-1:0]                mem_wdata,
    input  logic                             mem_resp,
    input  logic [LINE_W-1:0]                mem_rdata,
    output logic                             busy,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id
);

    localparam int GID_W = $clog2(NUM_REQ);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [GID_W-1:0]    gid_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   wdata_q;

    logic [NUM_REQ-1:0]  w_req;
    logic [NUM_REQ-1:0]  w_grant;
    logic                w_valid;
    logic [GID_W-1:0]    w_win_idx;
    logic [GID_W-1:0]    w_ptr;
    logic                w_grant_en;

    assign w_req = req_read | req_write;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (GID_W)
    ) u_picker (
        .req_i   (w_req),
        .ptr_i   (w_ptr),
        .grant_o (w_grant),
        .valid_o (w_valid)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_win_idx = GID_W'(i);
            end
        end
    end

`ifdef LINE_ARBITER_RR_EN
    logic [GID_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (w_grant_en) begin
            ptr_d = (w_win_idx == GID_W'(NUM_REQ - 1)) ? '0 : w_win_idx + GID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign w_ptr = ptr_q;
`else
    assign w_ptr = '0;
`endif

    // Requests are only looked at in IDLE; a write wins over a simultaneous read.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        w_grant_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_valid) begin
                    w_grant_en = 1'b1;
                    op_d       = req_write[w_win_idx] ? OP_WRITE : OP_READ;
                    state_d    = req_write[w_win_idx] ? ST_WRITE : ST_READ;
                end
            end
            ST_READ, ST_WRITE: begin
                if (mem_resp) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_READ;
            gid_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            if (w_grant_en) begin
                gid_q   <= w_win_idx;
                addr_q  <= req_address[w_win_idx];
                wdata_q <= req_wdata[w_win_idx];
            end
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign mem_read    = busy && (op_q == OP_READ);
    assign mem_write   = busy && (op_q == OP_WRITE);
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign grant_id    = gid_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign req_resp[i]  = busy && mem_resp && (gid_q == GID_W'(i));
        assign req_rdata[i] = ((state_q == ST_READ) && (gid_q == GID_W'(i))) ? mem_rdata : '0;
    end

endmodule : line_arbiter
`default_nettype wire

// File: tb/tb_line_arbiter.sv
`default_nettype none
// ============================================================================
// tb_line_arbiter : directed self-checking bench for line_arbiter
// Revision 1.0
// ============================================================================
module tb_line_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 256;
    localparam int GID_W   = 2;

    logic                            clk = 1'b0;
    logic                            rst;
    logic [NUM_REQ-1:0]              req_read;
    logic [NUM_REQ-1:0]              req_write;
    logic [NUM_REQ-1:0][ADDR_W-1:0]  req_address;
    logic [NUM_REQ-1:0][LINE_W-1:0]  req_wdata;
    logic [NUM_REQ-1:0]              req_resp;
    logic [NUM_REQ-1:0][LINE_W-1:0]  req_rdata;
    logic                            mem_read;
    logic                            mem_write;
    logic [ADDR_W-1:0]               mem_address;
    logic [LINE_W-1:0]               mem_wdata;
    logic                            mem_resp;
    logic [LINE_W-1:0]               mem_rdata;
    logic                            busy;
    logic [GID_W-1:0]                grant_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    line_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .LINE_W  (LINE_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_read    (req_read),
        .req_write   (req_write),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .req_resp    (req_resp),
        .req_rdata   (req_rdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int               exp_order [4];
    logic [LINE_W-1:0] pat;
    logic [LINE_W-1:0] a5;
    logic [NUM_REQ-1:0] onehot;

    initial begin
`ifdef LINE_ARBITER_RR_EN
        exp_order = '{0, 1, 2, 0};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        a5          = {32{8'hA5}};
        rst         = 1'b0;
        req_read    = '0;
        req_write   = '0;
        req_address = '0;
        req_wdata   = '0;
        mem_resp    = 1'b0;
        mem_rdata   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_gid", grant_id, 0);
        check("rst_mem_rd", mem_read, 0);
        check("rst_mem_wr", mem_write, 0);
        check("rst_mem_addr", mem_address, 0);
        check("rst_resp", req_resp, 0);
        next_cycle();
        rst = 1'b1;

        // Single read by requester 1, response after 4 command cycles
        req_read[1]    = 1'b1;
        req_address[1] = 32'h0000_1040;
        @(negedge clk);
        check("s1_c0_rd", mem_read, 0);
        pat = {8{32'hC0DE_0001}};
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            if (c == 4) begin
                mem_resp  = 1'b1;
                mem_rdata = pat;
            end
            @(negedge clk);
            check("s1_rd", mem_read, 1);
            check("s1_wr", mem_write, 0);
            check("s1_addr", mem_address, 32'h0000_1040);
            check("s1_gid", grant_id, 1);
            check("s1_busy", busy, 1);
            if (c < 4) check("s1_noresp", req_resp, 0);
        end
        check("s1_resp", req_resp, 3'b010);
        check("s1_rdata1", req_rdata[1], pat);
        check("s1_rdata0", req_rdata[0], 0);
        next_cycle();
        mem_resp = 1'b0;
        req_read = '0;
        @(negedge clk);
        check("s1_idle_rd", mem_read, 0);
        check("s1_idle_busy", busy, 0);
        check("s1_idle_resp", req_resp, 0);

        // All three requesters read continuously
        next_cycle();
        rst = 1'b0;
        next_cycle();
        rst      = 1'b1;
        req_read = 3'b111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("s2_idle", busy, 0);
            next_cycle();
            mem_resp  = 1'b1;
            mem_rdata = {8{32'h1111_0000 + k}};
            @(negedge clk);
            check("s2_gid", grant_id, exp_order[k]);
            check("s2_rd", mem_read, 1);
            onehot = '0;
            onehot[exp_order[k]] = 1'b1;
            check("s2_resp", req_resp, onehot);
            check("s2_rdata", req_rdata[exp_order[k]], {8{32'h1111_0000 + k}});
            next_cycle();
            mem_resp = 1'b0;
        end
        req_read = '0;

        // Requester 2 asserts read and write: write goes first
        next_cycle();
        req_read[2]    = 1'b1;
        req_write[2]   = 1'b1;
        req_wdata[2]   = a5;
        req_address[2] = 32'h0000_2000;
        @(negedge clk);
        check("s3_c0_wr", mem_write, 0);
        next_cycle();
        @(negedge clk);
        check("s3_wr", mem_write, 1);
        check("s3_rd", mem_read, 0);
        check("s3_wdata", mem_wdata, a5);
        check("s3_addr", mem_address, 32'h0000_2000);
        check("s3_gid", grant_id, 2);
        next_cycle();
        req_read  = '0;
        req_write = '0;
        @(negedge clk);
        check("s3_hold_wr", mem_write, 1);
        check("s3_hold_rd", mem_read, 0);
        next_cycle();
        mem_resp  = 1'b1;
        mem_rdata = {8{32'hDEAD_BEEF}};
        @(negedge clk);
        check("s3_resp", req_resp, 3'b100);
        check("s3_rdata2", req_rdata[2], 0);
        check("s3_rd_last", mem_read, 0);
        next_cycle();
        mem_resp = 1'b0;

        // Reset asserted mid-read
        req_read[2]    = 1'b1;
        req_address[2] = 32'h0000_3000;
        next_cycle();
        @(negedge clk);
        check("s4_rd", mem_read, 1);
        check("s4_gid", grant_id, 2);
        next_cycle();
        rst      = 1'b0;
        req_read = '0;
        #1;
        check("s4_rst_rd", mem_read, 0);
        check("s4_rst_busy", busy, 0);
        check("s4_rst_gid", grant_id, 0);
        next_cycle();
        rst      = 1'b1;
        mem_resp = 1'b1;
        @(negedge clk);
        check("s4_stale_resp", req_resp, 0);
        check("s4_stale_busy", busy, 0);
        next_cycle();
        mem_resp = 1'b0;
        @(negedge clk);
        check("s4_after_busy", busy, 0);

        // New request arrives in the response cycle
        next_cycle();
        req_read[1] = 1'b1;
        next_cycle();
        @(negedge clk);
        check("s5_gid1", grant_id, 1);
        check("s5_rd1", mem_read, 1);
        next_cycle();
        mem_resp = 1'b1;
        req_read = 3'b011;
        @(negedge clk);
        check("s5_resp1", req_resp, 3'b010);
        next_cycle();
        mem_resp = 1'b0;
        req_read = 3'b001;
        @(negedge clk);
        check("s5_gap_busy", busy, 0);
        check("s5_gap_rd", mem_read, 0);
        next_cycle();
        @(negedge clk);
        check("s5_busy0", busy, 1);
        check("s5_gid0", grant_id, 0);
        next_cycle();
        mem_resp = 1'b1;
        @(negedge clk);
        check("s5_resp0", req_resp, 3'b001);
        next_cycle();
        mem_resp = 1'b0;
        req_read = '0;
        @(negedge clk);
        check("s5_end_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_line_arbiter
`default_nettype wire
